// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared sizing helpers and defaults for sync_fifo_flags
package sync_fifo_pkg;

    // Number of bits needed to hold a count in the range 0..depth inclusive
    function automatic int level_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) <= depth) begin
            w++;
        end
        return w;
    endfunction

    // Entries in a FIFO addressed by depth_bits pointer bits
    function automatic int depth_of(input int depth_bits);
        return 1 << depth_bits;
    endfunction

    // almost_full threshold must be reachable and non-zero; almost_empty must be below full
    function automatic bit thresh_ok(input int af, input int ae, input int depth);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

    localparam int DEFAULT_DEPTH_BITS = 3;
    localparam int DEPTH              = depth_of(DEFAULT_DEPTH_BITS);
    localparam int LEVEL_W            = level_width(DEPTH);

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - dual-port storage, synchronous write, asynchronous read
module sync_fifo_ram #(
    parameter int DEPTH_BITS = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [DEPTH_BITS-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [DEPTH_BITS-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_BITS];

    // Storage is never reset; stale words are unreachable once pointers are cleared
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with level, threshold flags and sticky errors; SYNC_FIFO_FWFT_EN selects first-word-fall-through
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH_BITS = DEFAULT_DEPTH_BITS,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = (2**DEPTH_BITS) - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_BITS:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  half_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int FIFO_DEPTH = depth_of(DEPTH_BITS);
    localparam int LW         = DEPTH_BITS + 1;

    localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] L_HALF = LW'(FIFO_DEPTH / 2);
    localparam logic [LW-1:0] L_AF   = LW'(AF_THRESH);
    localparam logic [LW-1:0] L_AE   = LW'(AE_THRESH);

    generate
        if (!thresh_ok(AF_THRESH, AE_THRESH, FIFO_DEPTH) || level_width(FIFO_DEPTH) != LW) begin : g_bad_cfg
            $error("sync_fifo_flags: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
        end
    endgenerate

    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [DATA_WIDTH-1:0] w_mem_rd;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Full/empty come from the registered level so no request input reaches a flag
    assign w_full   = (r_level == L_FULL);
    assign w_empty  = (r_level == '0);
    assign w_wr_acc = wr_en && (!w_full || rd_en);
    assign w_rd_acc = rd_en && !w_empty;

    sync_fifo_ram #(
        .DEPTH_BITS (DEPTH_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rd)
    );

    // Pointers wrap naturally; level tracks the net effect of accepted push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle wins over clr_err
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full && !rd_en) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = w_mem_rd;
    assign rd_valid = !w_empty;
`else
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    // Registered read: popped word appears one cycle after the accepted pop, then holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_mem_rd;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`endif

    assign level        = r_level;
    assign empty        = w_empty;
    assign full         = w_full;
    assign half_full    = (r_level >= L_HALF);
    assign almost_empty = (r_level <= L_AE);
    assign almost_full  = (r_level >= L_AF);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
